// File: rtl/reg_exchange_pkg.sv
// Shared types and helpers for the register exchange unit.
//   xchg_mode_t : transaction mode encoding (11 is reserved)
//   xchg_lane   : per-bit exchange, returns {a', b'}
//   CNT_W       : width of the accepted-transaction counter
package reg_exchange_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        A_TO_B = 2'b00,
        B_TO_A = 2'b01,
        SWAP   = 2'b10,
        RSVD   = 2'b11
    } xchg_mode_t;

    // All bits of a lane share one enable, so working bitwise keeps this independent of lane width.
    function automatic logic [1:0] xchg_lane(input xchg_mode_t mode, input logic en,
                                             input logic a, input logic b);
        logic [1:0] r;
        r = {a, b};
        if (en) begin
            case (mode)
                A_TO_B:  r = {a, a};
                B_TO_A:  r = {b, b};
                SWAP:    r = {b, a};
                default: r = {a, b};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_exchange_if.sv
// Handshake and status bundle of the register exchange unit.
//   in_*     : producer side (valid/ready, mode, lane enables, A/B lanes)
//   out_*    : consumer side (valid/ready, transformed A/B, effective mode)
//   fill, xfer_cnt, err_mode : status
// master = producer/consumer environment, slave = the unit.
interface reg_exchange_if
    import reg_exchange_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 2
);
    localparam int unsigned LANES_W = CHANNELS * WIDTH;
    localparam int unsigned FILL_W  = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [MODE_W-1:0]   in_mode;
    logic [CHANNELS-1:0] in_chan_en;
    logic [LANES_W-1:0]  in_a;
    logic [LANES_W-1:0]  in_b;
    logic                out_valid;
    logic                out_ready;
    logic [LANES_W-1:0]  out_a;
    logic [LANES_W-1:0]  out_b;
    logic [MODE_W-1:0]   out_mode;
    logic [FILL_W-1:0]   fill;
    logic [CNT_W-1:0]    xfer_cnt;
    logic                err_mode;

    modport master (
        output in_valid, in_mode, in_chan_en, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_mode, fill, xfer_cnt, err_mode
    );

    modport slave (
        input  in_valid, in_mode, in_chan_en, in_a, in_b, out_ready,
        output in_ready, out_valid, out_a, out_b, out_mode, fill, xfer_cnt, err_mode
    );

endinterface

// File: rtl/reg_exchange_fifo.sv
// Synchronous FIFO; occupancy count is the sole full/empty discriminator.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i, data_i   : write request (ignored when full, even if popping)
//   pop_i            : read request (ignored when empty)
//   data_o           : head entry, held until popped
//   full_o, empty_o, fill_o : occupancy status
module reg_exchange_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     fill_o
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              push_ok_c, pop_ok_c;

    assign full_o  = (fill_q == FILL_W'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign fill_o  = fill_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok_c = push_i & ~full_o;
    assign pop_ok_c  = pop_i & ~empty_o;

    // Occupancy update
    always_comb begin
        fill_d = fill_q;
        case ({push_ok_c, pop_ok_c})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fill_q <= fill_d;
            if (push_ok_c) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/reg_exchange_unit.sv
// Multi-lane register exchange engine: per accepted transaction copies A->B, B->A or swaps
// A/B on each enabled lane, then buffers {mode, a', b'} in an output FIFO.
//   sysclk, rst : clock, synchronous active-high reset
//   bus         : reg_exchange_if slave (input/output handshakes, data, status)
module reg_exchange_unit
    import reg_exchange_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned DEPTH        = 2,
    parameter logic [1:0]  DEFAULT_MODE = 2'b10
) (
    input  logic           sysclk,
    input  logic           rst,
    reg_exchange_if.slave  bus
);
    localparam int unsigned LANES_W = CHANNELS * WIDTH;
    localparam int unsigned DATA_W  = MODE_W + 2 * LANES_W;

    xchg_mode_t           eff_mode_c;
    logic [LANES_W-1:0]   a_x_c, b_x_c;
    logic                 accept_c;
    logic                 fifo_full, fifo_empty;
    logic [DATA_W-1:0]    head;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Reserved mode falls back to the configured default
    always_comb begin
        eff_mode_c = xchg_mode_t'(bus.in_mode);
        if (xchg_mode_t'(bus.in_mode) == RSVD) begin
            eff_mode_c = xchg_mode_t'(DEFAULT_MODE);
        end
    end

    // Lane transform, applied at FIFO write
    always_comb begin
        a_x_c = '0;
        b_x_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            for (int unsigned j = 0; j < WIDTH; j++) begin
                {a_x_c[k*WIDTH+j], b_x_c[k*WIDTH+j]} =
                    xchg_lane(eff_mode_c, bus.in_chan_en[k],
                              bus.in_a[k*WIDTH+j], bus.in_b[k*WIDTH+j]);
            end
        end
    end

    // in_ready depends only on registered occupancy, never on out_ready
    assign accept_c  = bus.in_valid & ~fifo_full;
    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_mode  = head[DATA_W-1 -: MODE_W];
    assign bus.out_a     = head[2*LANES_W-1 -: LANES_W];
    assign bus.out_b     = head[LANES_W-1:0];
    assign bus.xfer_cnt  = cnt_q;
    assign bus.err_mode  = err_q;

    reg_exchange_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (sysclk),
        .rst_i   (rst),
        .push_i  (bus.in_valid),
        .data_i  ({eff_mode_c, a_x_c, b_x_c}),
        .pop_i   (bus.out_ready),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .fill_o  (bus.fill)
    );

    // Transaction counter and sticky reserved-mode flag
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (xchg_mode_t'(bus.in_mode) == RSVD) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_exchange_unit.sv
// Self-checking bench for reg_exchange_unit (WIDTH=8, CHANNELS=4, DEPTH=2, DEFAULT_MODE=SWAP).
module tb_reg_exchange_unit;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;

    always #5 sysclk = ~sysclk;

    reg_exchange_if #(.WIDTH(8), .CHANNELS(4), .DEPTH(2)) bus ();

    reg_exchange_unit #(
        .WIDTH(8), .CHANNELS(4), .DEPTH(2), .DEFAULT_MODE(2'b10)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [3:0]  en;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [1:0]  emode;
        logic        eerr;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    exp_t sbq[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane-level reference model of the exchange
    function automatic exp_t model(input logic [1:0] m, input logic [3:0] en,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t       r;
        logic [1:0] e;
        logic [7:0] la, lb;
        e      = (m == 2'b11) ? 2'b10 : m;
        r.mode = e;
        r.a    = a;
        r.b    = b;
        for (int k = 0; k < 4; k++) begin
            if (en[k]) begin
                la = a[k*8 +: 8];
                lb = b[k*8 +: 8];
                case (e)
                    2'b00:   begin r.a[k*8 +: 8] = la; r.b[k*8 +: 8] = la; end
                    2'b01:   begin r.a[k*8 +: 8] = lb; r.b[k*8 +: 8] = lb; end
                    default: begin r.a[k*8 +: 8] = lb; r.b[k*8 +: 8] = la; end
                endcase
            end
        end
        return r;
    endfunction

    // Scoreboard: compare pops against the queue, then record accepts
    always @(negedge sysclk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_out_a", bus.out_a, e.a);
                    chk("sb_out_b", bus.out_b, e.b);
                    chk("sb_out_mode", 32'(bus.out_mode), 32'(e.mode));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(bus.in_mode, bus.in_chan_en, bus.in_a, bus.in_b));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge sysclk);
        #1 rst = 1'b0;
    endtask

    task automatic set_in(input logic [1:0] m, input logic [3:0] en,
                          input logic [31:0] a, input logic [31:0] b);
        bus.in_mode    = m;
        bus.in_chan_en = en;
        bus.in_a       = a;
        bus.in_b       = b;
    endtask

    initial begin
        int  sent;
        int  cyc;
        bit  acc;
        bit  done;
        int  pops0;

        vecs[0] = '{2'b10, 4'hF, 32'h44332211, 32'hDDCCBBAA, 32'hDDCCBBAA, 32'h44332211, 2'b10, 1'b0};
        vecs[1] = '{2'b00, 4'h5, 32'h44332211, 32'hDDCCBBAA, 32'h44332211, 32'hDD33BB11, 2'b00, 1'b0};
        vecs[2] = '{2'b01, 4'hF, 32'h44332211, 32'hDDCCBBAA, 32'hDDCCBBAA, 32'hDDCCBBAA, 2'b01, 1'b0};
        vecs[3] = '{2'b01, 4'hA, 32'h44332211, 32'hDDCCBBAA, 32'hDD33BB11, 32'hDDCCBBAA, 2'b01, 1'b0};
        vecs[4] = '{2'b10, 4'h0, 32'h44332211, 32'hDDCCBBAA, 32'h44332211, 32'hDDCCBBAA, 2'b10, 1'b0};
        vecs[5] = '{2'b10, 4'h8, 32'h44332211, 32'hDDCCBBAA, 32'hDD332211, 32'h44CCBBAA, 2'b10, 1'b0};
        vecs[6] = '{2'b11, 4'hF, 32'h44332211, 32'hDDCCBBAA, 32'hDDCCBBAA, 32'h44332211, 2'b10, 1'b1};

        set_in(2'b00, 4'h0, 32'h0, 32'h0);
        do_reset();

        // Reset state
        @(negedge sysclk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_fill",      32'(bus.fill),      32'd0);
        chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  32'd0);
        chk("rst_err_mode",  32'(bus.err_mode),  32'd0);
        chk("rst_out_a",     bus.out_a,          32'd0);
        chk("rst_out_b",     bus.out_b,          32'd0);
        chk("rst_out_mode",  32'(bus.out_mode),  32'd0);

        // Table-driven single transactions, one-cycle accept-to-head latency
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge sysclk); #1;
            set_in(vecs[i].mode, vecs[i].en, vecs[i].a, vecs[i].b);
            bus.in_valid = 1'b1;
            @(posedge sysclk); #1;
            bus.in_valid = 1'b0;
            @(negedge sysclk);
            chk("vec_out_valid", 32'(bus.out_valid), 32'd1);
            chk("vec_out_a",     bus.out_a,          vecs[i].ea);
            chk("vec_out_b",     bus.out_b,          vecs[i].eb);
            chk("vec_out_mode",  32'(bus.out_mode),  32'(vecs[i].emode));
            chk("vec_err_mode",  32'(bus.err_mode),  32'(vecs[i].eerr));
            chk("vec_xfer_cnt",  32'(bus.xfer_cnt),  32'(i + 1));
        end

        // Sticky error survives idle cycles, cleared by reset
        repeat (10) @(posedge sysclk);
        @(negedge sysclk);
        chk("err_sticky", 32'(bus.err_mode), 32'd1);
        do_reset();
        @(negedge sysclk);
        chk("err_cleared", 32'(bus.err_mode), 32'd0);

        // Backpressure at DEPTH=2: third push held, outputs drain in order
        pops0 = pops;
        @(posedge sysclk); #1;
        set_in(2'b10, 4'hF, 32'h01020304, 32'hA0B0C0D0);
        bus.in_valid = 1'b1;
        @(negedge sysclk);
        chk("bp_fill0", 32'(bus.fill), 32'd0);
        @(posedge sysclk); #1;
        set_in(2'b00, 4'h3, 32'h11111111, 32'h22222222);
        @(negedge sysclk);
        chk("bp_fill1",  32'(bus.fill),     32'd1);
        chk("bp_ready1", 32'(bus.in_ready), 32'd1);
        @(posedge sysclk); #1;
        set_in(2'b01, 4'hC, 32'h33333333, 32'h44444444);
        @(negedge sysclk);
        chk("bp_fill2",   32'(bus.fill),     32'd2);
        chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
        chk("bp_head",    bus.out_a,         32'hA0B0C0D0);
        @(posedge sysclk); #1;
        @(negedge sysclk);
        chk("bp_fill_hold",  32'(bus.fill),  32'd2);
        chk("bp_head_hold",  bus.out_a,      32'hA0B0C0D0);
        bus.out_ready = 1'b1;
        @(posedge sysclk); #1;
        @(negedge sysclk);
        chk("bp_fill_pop1",  32'(bus.fill),     32'd1);
        chk("bp_ready_open", 32'(bus.in_ready), 32'd1);
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        @(negedge sysclk);
        chk("bp_fill_pushpop", 32'(bus.fill), 32'd1);
        @(posedge sysclk); #1;
        @(negedge sysclk);
        chk("bp_fill_empty", 32'(bus.fill),      32'd0);
        chk("bp_out_valid",  32'(bus.out_valid), 32'd0);
        chk("bp_pops",       32'(pops - pops0),  32'd3);
        chk("bp_sb_empty",   32'(sbq.size()),    32'd0);

        // Random valid/ready traffic against the scoreboard
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            @(negedge sysclk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge sysclk); #1;
            if (acc) sent++;
            if (acc || !bus.in_valid) begin
                bus.in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
                set_in(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_sent", 32'(sent), 32'd1000);
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge sysclk);
            done = (sbq.size() == 0) && !bus.out_valid;
        end
        chk("rand_drained", 32'(done), 32'd1);
        chk("rand_xfer_cnt", 32'(bus.xfer_cnt), 32'd1000);

        // Counter wrap: sustained traffic up to 16'hFFFF, then one more accept
        @(posedge sysclk); #1;
        set_in(2'b10, 4'h5, 32'hCAFEF00D, 32'h12345678);
        bus.in_valid = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 70000 && !done; c++) begin
            @(negedge sysclk);
            done = (bus.xfer_cnt == 16'hFFFF);
        end
        chk("wrap_preload", 32'(bus.xfer_cnt), 32'h0000FFFF);
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        @(negedge sysclk);
        chk("wrap_zero", 32'(bus.xfer_cnt), 32'd0);
        repeat (3) @(posedge sysclk);
        #1;

        // Reset while full discards contents
        bus.out_ready = 1'b0;
        set_in(2'b00, 4'hF, 32'h55555555, 32'h66666666);
        bus.in_valid = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 bus.in_valid = 1'b0;
        @(negedge sysclk);
        chk("mid_fill2", 32'(bus.fill), 32'd2);
        @(posedge sysclk); #1;
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        @(negedge sysclk);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_fill",      32'(bus.fill),      32'd0);
        chk("mid_in_ready",  32'(bus.in_ready),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
